// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in / serial-out serializer. Accepts a WIDTH-bit word
//               on a valid/ready handshake and emits it LSB first, one bit per
//               clock, starting the cycle after accept. A new word may be
//               accepted in the final-bit cycle so frames run back-to-back
//               without an idle cycle.
// Build macro : PISO_SERIALIZER_PARITY_EN -- when defined, each frame carries
//               one extra trailing bit holding the even parity (XOR) of the
//               accepted word, and q_last marks that parity bit.
// Ports       : clk      - clock, all state updates on rising edge
//               rst_n    - asynchronous active-low reset
//               in_valid - upstream word available
//               in_data  - parallel word, sampled only on accept
//               in_ready - serializer can take a word this cycle
//               q        - serial data bit (0 when q_valid is 0)
//               q_valid  - q carries a frame bit this cycle
//               q_last   - q carries the final bit of the frame
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             q,
  output logic             q_valid,
  output logic             q_last
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  // Sized to hold WIDTH+1 so the parity index fits without wrapping.
  localparam int              CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(WIDTH);
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic               w_last;
  logic               w_accept;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. All are decoded from registered state so the asynchronous reset
  // drives them low immediately. in_ready is additionally gated by rst_n:
  // the reset state is IDLE, which would otherwise advertise ready while
  // reset is still asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    q_valid  = (state_q == SHIFT);
    w_last   = q_valid && (cnt_q == LAST_IDX);
    q_last   = w_last;
    in_ready = rst_n && ((state_q == IDLE) || w_last);
    w_accept = in_valid && in_ready;
`ifdef PISO_SERIALIZER_PARITY_EN
    if (cnt_q == PAR_IDX) begin
      q = q_valid && parity_q;
    end else begin
      q = q_valid && shreg_q[0];
    end
`else
    q = q_valid && shreg_q[0];
`endif
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef PISO_SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif

    if (w_accept) begin
      // Covers both a fresh start from IDLE and a back-to-back reload in
      // the final-bit cycle.
      state_d  = SHIFT;
      shreg_d  = in_data;
      cnt_d    = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_d = ^in_data;
`endif
    end else if (state_q == SHIFT) begin
      if (w_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        // The word drains through bit 0; once the data bits are exhausted
        // the parity bit (if built) is selected by the counter instead.
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer (WIDTH=8). A queue
//               model holds the bits still owed on the serial line; every
//               accepted word appends its frame, every clock removes the bit
//               just shown. A compare process checks the DUT against the
//               queue head each cycle; directed tests add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  localparam int WIDTH = 8;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data  = '0;
  logic             in_ready;
  logic             q;
  logic             q_valid;
  logic             q_last;

  int vectors     = 0;
  int miscompares = 0;

  // Bits still to be emitted, and the matching "final bit" flags.
  bit mq[$];
  bit ml[$];

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .q        (q),
    .q_valid  (q_valid),
    .q_last   (q_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a queue of owed bits.
  // --------------------------------------------------------------------------
  always @(posedge clk or negedge rst_n) begin
    bit rdy;
    if (!rst_n) begin
      mq.delete();
      ml.delete();
    end else begin
      rdy = (mq.size() == 0);
      if (mq.size() != 0) begin
        rdy = rdy || ml[0];
        void'(mq.pop_front());
        void'(ml.pop_front());
      end
      if (in_valid && rdy) begin
        for (int i = 0; i < WIDTH; i++) begin
          mq.push_back(in_data[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
          ml.push_back(1'b0);
`else
          ml.push_back(i == WIDTH - 1);
`endif
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        mq.push_back(^in_data);
        ml.push_back(1'b1);
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison against the model, away from the active edge.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    bit ev, eq, el, er;
    ev = 1'b0; eq = 1'b0; el = 1'b0;
    if (rst_n && mq.size() != 0) begin
      ev = 1'b1;
      eq = mq[0];
      el = ml[0];
    end
    er = rst_n && (!ev || el);
    chk("model_q_valid",  q_valid,  ev);
    chk("model_q",        q,        eq);
    chk("model_q_last",   q_last,   el);
    chk("model_in_ready", in_ready, er);
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations.
  // --------------------------------------------------------------------------
  initial begin
    logic [7:0] pat;
    logic [8:0] ppat;
    logic [7:0] b1, b2;

    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_q_valid",  q_valid,  1'b0);
    chk("rst_q",        q,        1'b0);
    chk("rst_q_last",   q_last,   1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef PISO_SERIALIZER_PARITY_EN
    // Single word 0xA5.
    pat = 8'hA5;
    step(); in_valid = 1'b1; in_data = 8'hA5;
    step(); in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        chk("t1_q",     q,       pat[k-1]);
        chk("t1_valid", q_valid, 1'b1);
        chk("t1_last",  q_last,  (k == 8));
      end else begin
        chk("t1_valid_after", q_valid, 1'b0);
      end
    end

    // Back-to-back 0xFF then 0x00, second word waiting with in_valid high.
    step(); in_valid = 1'b1; in_data = 8'hFF;
    step(); in_data = 8'h00;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk("t2_valid", q_valid, (k <= 16));
      chk("t2_q",     q,       (k <= 8));
      chk("t2_last",  q_last,  (k == 8 || k == 16));
      if (k <= 8) chk("t2_ready", in_ready, (k == 8));
      if (k == 8) begin
        @(posedge clk); #1; in_valid = 1'b0;
      end
    end

    // Stall: in_data churns while busy; value present in last cycle wins.
    step(); in_valid = 1'b1; in_data = 8'h81;
    step(); in_data = 8'h11;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        b1[k-1] = q;
        chk("t3_ready", in_ready, (k == 8));
      end else begin
        b2[k-9] = q;
      end
      @(posedge clk); #1;
      if (k + 1 == 8)      in_data = 8'h3C;
      else if (k + 1 == 9) begin in_valid = 1'b0; in_data = 8'hFF; end
      else                 in_data = in_data + 8'h1D;
    end
    chk("t3_frame1", b1, 8'h81);
    chk("t3_frame2", b2, 8'h3C);
`else
    // Parity: 0x07 has odd weight, so the trailing parity bit is 1.
    ppat = 9'b1_0000_0111;
    step(); in_valid = 1'b1; in_data = 8'h07;
    step(); in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("p1_q",    q,      ppat[k-1]);
      chk("p1_last", q_last, (k == 9));
    end
    step(); in_valid = 1'b1; in_data = 8'h03;
    step(); in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("p2_parity", q,      1'b0);
    chk("p2_last",   q_last, 1'b1);
    pat = 8'h00;
`endif

    // Reset mid-frame after bit 3 of 0xA5.
    step(); in_valid = 1'b1; in_data = 8'hA5;
    step(); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_pre_valid", q_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", q_valid,  1'b0);
    chk("t4_rst_q",     q,        1'b0);
    chk("t4_rst_last",  q_last,   1'b0);
    chk("t4_rst_ready", in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_ready", in_ready, 1'b1);
      chk("t4_idle",  q_valid,  1'b0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream word available.
REQ-005 in_data  input  WIDTH  parallel word; sampled only on accept.
REQ-006 in_ready  output  1  serializer can take a word this cycle.
REQ-007 q  output  1  serial data bit.
REQ-008 q_valid  output  1  q carries a frame bit this cycle.
REQ-009 q_last  output  1  q carries the final bit of the current frame.

Function
REQ-010 The block SHALL have two states: IDLE and SHIFT.
REQ-011 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-012 in_ready SHALL be 1 in IDLE, 1 in SHIFT only while q_last=1, 0 otherwise, and 0 while rst_n=0.
REQ-013 On accept, in_data SHALL be loaded into a WIDTH-bit shift register; the bit counter SHALL be set to 0; the state SHALL become SHIFT.
REQ-014 Latency: bit 0 of an accepted word SHALL appear on q in the cycle after accept (one-cycle load latency).
REQ-015 Bits SHALL be sent LSB first, one per cycle, with no gaps: bit k appears k+1 cycles after accept.
REQ-016 q_valid SHALL be 1 in every SHIFT cycle and 0 in IDLE; q SHALL be 0 whenever q_valid=0.
REQ-017 The frame length N SHALL be WIDTH (or WIDTH+1 per REQ-028); q_last SHALL be 1 only on bit N-1 of the frame.
REQ-018 The bit counter SHALL be $clog2(WIDTH+2) bits wide and SHALL not wrap within a frame.
REQ-019 After q_last with no accept, the state SHALL return to IDLE on the next edge.
REQ-020 Back-to-back: an accept in the q_last cycle SHALL make bit 0 of the new word appear in the next cycle, with q_valid held at 1 and no idle cycle.
REQ-021 in_data changes while in_ready=0 SHALL have no effect on the frame in flight.
REQ-022 In SHIFT, in_valid=1 with in_ready=0 SHALL not accept; the word SHALL be accepted no earlier than the q_last cycle.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force the state to IDLE and q, q_valid, q_last to 0.
REQ-024 rst_n=0 SHALL clear the shift register and bit counter to 0.
REQ-025 Reset mid-frame SHALL abort the frame; the remaining bits SHALL never be emitted.
REQ-026 After rst_n rises, the first accept SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-027 The macro PISO_SERIALIZER_PARITY_EN SHALL control the parity feature.
REQ-028 With PISO_SERIALIZER_PARITY_EN defined: N=WIDTH+1; bit WIDTH SHALL be the even parity (XOR of all in_data bits captured at accept); q_last SHALL be on the parity bit.
REQ-029 Without the macro: N=WIDTH; no parity logic SHALL be synthesized; q_last SHALL be on data bit WIDTH-1.

Verification (WIDTH=8)
REQ-030 Single word, parity off: accept 0xA5 at cycle 0 -> q=1,0,1,0,0,1,0,1 on cycles 1..8; q_valid=1 on cycles 1..8; q_last=1 on cycle 8 only; q_valid=0 on cycle 9.
REQ-031 Back-to-back, parity off: accept 0xFF at cycle 0 and 0x00 at cycle 8 -> q_valid=1 on cycles 1..16; q=1 on cycles 1..8 and 0 on cycles 9..16; q_last=1 on cycles 8 and 16.
REQ-032 Parity on: accept 0x07 -> q=1,1,1,0,0,0,0,0 then 1 on cycle 9 with q_last=1. Accept 0x03 -> parity bit 0 on cycle 9.
REQ-033 Stall, parity off: hold in_valid=1 with in_data=0x3C during a frame; change in_data each cycle -> in_ready=0 and the in-flight frame is unchanged; the value present in the q_last cycle is accepted.
REQ-034 Reset mid-frame: drive rst_n=0 asynchronously after bit 3 of 0xA5 -> q, q_valid, q_last=0 immediately; after release, in_ready=1 and no residual bits are emitted.
